// File: rtl/seq_fsm_control_if.sv
// Control-word bus from the sequencer to the systolic/buffer/accumulator datapath.
// The master presents flags/addr with valid; the slave accepts with ready.
interface seq_fsm_control_if #(
    parameter int DP_ADDR_WIDTH = 10
);
    logic                     ctrl_valid;
    logic                     ctrl_ready;
    logic [15:0]              ctrl_flags;
    logic [DP_ADDR_WIDTH-1:0] ctrl_addr;

    modport master (
        output ctrl_valid,
        output ctrl_flags,
        output ctrl_addr,
        input  ctrl_ready
    );

    modport slave (
        input  ctrl_valid,
        input  ctrl_flags,
        input  ctrl_addr,
        output ctrl_ready
    );
endinterface

// File: rtl/seq_fsm_control.sv
// Instruction sequencer for the systolic-array VPU.
// Fetches from a synchronous instruction RAM (latency 0..3), decodes HALT / LOOP / NOP,
// and issues control words over a valid/ready bus. Run/step/halt debug control pauses
// and resumes only at instruction boundaries.
module seq_fsm_control #(
    parameter int INSTR_WIDTH   = 32,
    parameter int INSTR_DEPTH   = 256,
    parameter int DP_ADDR_WIDTH = 10,
    parameter int MEM_LATENCY   = 1,
    localparam int PC_W         = $clog2(INSTR_DEPTH)
) (
    input  logic                   clk,
    input  logic                   fsm_rst,
    input  logic                   run,
    input  logic                   step,
    input  logic                   halt,
    output logic [PC_W-1:0]        rd_addr,
    input  logic [INSTR_WIDTH-1:0] rd_data,
    seq_fsm_control_if.master      ctrl,
    output logic [PC_W-1:0]        pc_out,
    output logic [INSTR_WIDTH-1:0] curr_instr_out,
    output logic [7:0]             loop_cnt_out,
    output logic [2:0]             state_out,
    output logic                   done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state_q;
    logic [PC_W-1:0]        pc_q;
    logic [7:0]             lc_q;
    logic                   loaded_q;
    logic                   step_mode_q;
    logic                   step_q;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [1:0]             wait_q;

    logic                   is_halt;
    logic                   is_loop;
    logic                   is_nop;
    logic                   is_ctrl;
    logic                   issue_done;
    logic [7:0]             loop_count;
    logic [PC_W-1:0]        loop_target;
    logic [PC_W-1:0]        pc_d;
    logic [7:0]             lc_d;
    logic                   loaded_d;

    assign is_halt     = instr_q[18];
    assign is_loop     = !instr_q[18] && instr_q[19];
    assign is_nop      = !instr_q[18] && !instr_q[19] && instr_q[20];
    assign is_ctrl     = !is_halt && !is_loop && !is_nop;
    assign loop_count  = instr_q[15:8];
    assign loop_target = instr_q[PC_W-1:0];

    // An instruction retires in ISSUE once it is not HALT and, for control words, accepted.
    assign issue_done = (state_q == S_ISSUE) && !is_halt && (!is_ctrl || ctrl.ctrl_ready);

    // Next pc and loop-counter state for the instruction currently in ISSUE.
    always_comb begin
        pc_d     = pc_q + PC_W'(1);
        lc_d     = lc_q;
        loaded_d = loaded_q;
        if (is_loop) begin
            if (!loaded_q) begin
                if (loop_count != 8'd0) begin
                    lc_d     = loop_count - 8'd1;
                    loaded_d = 1'b1;
                    pc_d     = loop_target;
                end
            end else if (lc_q != 8'd0) begin
                lc_d = lc_q - 8'd1;
                pc_d = loop_target;
            end else begin
                loaded_d = 1'b0;
            end
        end
    end

    // Sequencer FSM: fetch, wait out RAM latency, issue, then pause or continue.
    always_ff @(posedge clk) begin
        if (fsm_rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            lc_q        <= '0;
            loaded_q    <= 1'b0;
            step_mode_q <= 1'b0;
            step_q      <= 1'b0;
            instr_q     <= '0;
            wait_q      <= '0;
        end else begin
            step_q <= step;
            case (state_q)
                S_IDLE: begin
                    if (!halt) begin
                        if (run) begin
                            step_mode_q <= 1'b0;
                            state_q     <= S_FETCH;
                        end else if (step && !step_q) begin
                            step_mode_q <= 1'b1;
                            state_q     <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (MEM_LATENCY == 0) begin
                        instr_q <= rd_data;
                        state_q <= S_ISSUE;
                    end else begin
                        wait_q  <= 2'(MEM_LATENCY - 1);
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_q == 2'd0) begin
                        instr_q <= rd_data;
                        state_q <= S_ISSUE;
                    end else begin
                        wait_q <= wait_q - 2'd1;
                    end
                end
                S_ISSUE: begin
                    if (is_halt) begin
                        state_q <= S_DONE;
                    end else if (issue_done) begin
                        pc_q     <= pc_d;
                        lc_q     <= lc_d;
                        loaded_q <= loaded_d;
                        if (halt || step_mode_q || !run) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_addr         = pc_q;
    assign pc_out          = pc_q;
    assign curr_instr_out  = instr_q;
    assign loop_cnt_out    = lc_q;
    assign state_out       = state_q;
    assign done            = (state_q == S_DONE);
    assign ctrl.ctrl_valid = (state_q == S_ISSUE) && is_ctrl;
    assign ctrl.ctrl_flags = instr_q[31:16];
    assign ctrl.ctrl_addr  = instr_q[DP_ADDR_WIDTH-1:0];

endmodule

// File: doc/seq_fsm_control.md
# seq_fsm_control

Parametrised instruction sequencer for the systolic-array VPU, successor to the single-cycle tiny control FSM. It fetches instructions from a synchronous instruction RAM with configurable read latency and issues control words to the datapath over a valid/ready handshake. It adds three capabilities:
- a hardware loop counter;
- an in-stream HALT instruction;
- run / step / halt debug control with pause-and-resume at instruction boundaries.

It sits between the UART-loaded instruction memory and the systolic/buffer/accumulator datapath.

## Interface
- INSTR_WIDTH, 32: instruction width. Must be ≥ 32.
- INSTR_DEPTH, 256: number of instruction words. Power of two, ≤ 256. PC_W = $clog2(INSTR_DEPTH).
- DP_ADDR_WIDTH, 10: width of the datapath address operand.
- MEM_LATENCY, 1: instruction RAM read latency in cycles, from rd_addr to rd_data. Legal range 0..3.

Ports (reset is synchronous and active-high):
- clk, in, 1: single clock.
- fsm_rst, in, 1: synchronous active-high reset.
- run, in, 1: level. Execute continuously while high.
- step, in, 1: rising edge executes one instruction.
- halt, in, 1: level. Pause at the next instruction boundary. Has priority over run and step.
- rd_addr, out, PC_W: instruction RAM address.
- rd_data, in, INSTR_WIDTH: instruction RAM data.
- ctrl_valid, out, 1: a control word is presented to the datapath.
- ctrl_ready, in, 1: datapath accepts the control word.
- ctrl_flags, out, 16: instr[31:16] of the issued instruction.
- ctrl_addr, out, DP_ADDR_WIDTH: instr[DP_ADDR_WIDTH-1:0] of the issued instruction.
- pc_out, out, PC_W: current program counter.
- curr_instr_out, out, INSTR_WIDTH: last captured instruction.
- loop_cnt_out, out, 8: remaining loop jumps.
- state_out, out, 3: encoded FSM state.
- done, out, 1: high while in DONE.

## Operation
Instruction decode priority:
- instr[18] = HALT.
- instr[19] = LOOP, with count = instr[15:8] and target = instr[PC_W-1:0].
- instr[20] = NOP.
- Any other instruction is a control instruction.

States and encodings: IDLE=0, FETCH=1, WAIT=2, ISSUE=3, DONE=4.

- **IDLE**
  - halt=1: stay in IDLE.
  - run=1: go to FETCH with step_mode=0.
  - step rising edge (step high, step_d low): go to FETCH with step_mode=1.
- **FETCH**
  - rd_addr=pc.
  - MEM_LATENCY=0: capture rd_data into curr_instr at this edge, go to ISSUE.
  - Otherwise go to WAIT.
- **WAIT**
  - Hold rd_addr for MEM_LATENCY cycles, then capture rd_data and go to ISSUE.
- **ISSUE**
  - HALT: go to DONE. pc is unchanged and there is no ctrl_valid.
  - NOP: pc+1.
  - Control instruction:
    - ctrl_valid=1 with ctrl_flags and ctrl_addr held stable until ctrl_ready=1, then pc+1.
    - Nothing else leaves ISSUE while valid is unaccepted, including halt and run deassert.
  - LOOP (single counter lc plus a loaded bit; nested loops are unsupported):
    - Not loaded, count=0: pc+1.
    - Not loaded, count>0: lc=count-1, loaded=1, pc=target.
    - Loaded, lc>0: lc=lc-1, pc=target.
    - Loaded, lc=0: loaded=0, pc+1.
  - On completion, the next state is chosen in this priority order:
    1. halt → IDLE.
    2. step_mode → IDLE.
    3. run=0 → IDLE.
    4. Otherwise → FETCH.
- **DONE**
  - Terminal state. Only fsm_rst exits it.
- pc increments from INSTR_DEPTH-1 and wraps to 0.
- Resuming from IDLE continues at the held pc, with lc and loaded preserved.
- fsm_rst in any state, including mid-handshake, takes effect at the next edge:
  - Goes to IDLE with pc=0, lc=0, loaded=0, curr_instr=0.
  - ctrl_valid drops.

## Timing
- Reset values of all outputs:
  - state_out=0, pc_out=0, rd_addr=0, curr_instr_out=0, loop_cnt_out=0.
  - ctrl_valid=0, ctrl_flags=0, ctrl_addr=0, done=0.
- All outputs are registered or decoded from registers only. There is no combinational path from ctrl_ready to ctrl_valid.
- ctrl_valid is high in exactly the ISSUE cycles of control instructions.
- Throughput with ctrl_ready=1 is one instruction per 2+MEM_LATENCY cycles:
  - FETCH: 1 cycle.
  - WAIT: MEM_LATENCY cycles.
  - ISSUE: 1 cycle.
- Each cycle of ctrl_ready=0 adds one ISSUE cycle.
- A handshake occurs on a cycle with ctrl_valid & ctrl_ready. pc updates at that edge.
- step, run and halt are sampled at each edge. step requires one low cycle between pulses.
- done asserts in the cycle after the ISSUE that decoded HALT.

## Test plan
- **Reset:** hold fsm_rst for 5 cycles → every output is 0 and state_out=0. Raise run=1 with halt=0 → state_out goes 1 then 2 then 3.
- **Straight line:** MEM_LATENCY=1, ctrl_ready=1, mem[0]=0x8000_0001, mem[1]=0x4000_0002, mem[2]=HALT 0x0004_0000.
  - ctrl_valid pulses with flags 0x8000 / addr 1, then flags 0x4000 / addr 2, 3 cycles apart.
  - Then done=1 with pc_out=2.
- **Backpressure:** hold ctrl_ready=0 for 4 cycles on 0x0800_2F30 → ctrl_valid is held 5 cycles with flags 0x0800 and addr 0x330 (DP_ADDR_WIDTH=10) constant. pc increments once.
- **Loop:** mem[0]=0x0200_0005, mem[1]=0x0008_0200 (LOOP, count=2, target=0), mem[2]=HALT.
  - Exactly 3 ctrl_valid handshakes with flags 0x0200.
  - loop_cnt_out sequence 1, 0, 0.
  - Ends in DONE.
- **Step and halt:**
  - Five step pulses with run=0 → exactly 5 instructions, state_out=0 between them, pc_out 1 through 5.
  - Then run=1, and assert halt mid-stream during a held ISSUE → the handshake completes, then state goes to 0.
  - Release halt → execution resumes at the held pc.
- **Reset mid-operation:** fsm_rst pulsed while ctrl_valid=1 with ctrl_ready=0 → the next cycle has ctrl_valid=0, pc_out=0 and state_out=0. A subsequent run restarts from mem[0].
